// File: rtl/sub_pipe_defs.sv
// Shared definitions for the two-stage pipelined subtractor (sub_pipe2).
//   DefaultWidth : default operand width
//   Half         : half of the default width (one pipeline stage's slice)
//   Rst*         : reset values of the stage registers
package sub_pipe_defs;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned Half         = DefaultWidth / 2;

  localparam logic RstValid  = 1'b0;
  localparam logic RstBorrow = 1'b0;
  localparam logic RstFlag   = 1'b0;

endpackage

// File: rtl/sub_half.sv
// Combinational H-bit subtract with borrow: {o_bout, o_diff} = i_a - i_b - i_bin.
// Ports:
//   i_a, i_b  in  H  minuend / subtrahend slice
//   i_bin     in  1  borrow-in
//   o_diff    out H  difference modulo 2^H
//   o_bout    out 1  borrow-out (unsigned i_a < i_b + i_bin)
module sub_half
  import sub_pipe_defs::*;
#(
  parameter int unsigned H = Half
) (
  input  logic [H-1:0] i_a,
  input  logic [H-1:0] i_b,
  input  logic         i_bin,
  output logic [H-1:0] o_diff,
  output logic         o_bout
);

  logic [H:0] w_full;

  // Computed one bit wider; a borrow shows up as the extra MSB wrapping to 1.
  assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{H{1'b0}}, i_bin};
  assign o_diff = w_full[H-1:0];
  assign o_bout = w_full[H];

endmodule

// File: rtl/sub_pipe2.sv
// Two-stage pipelined subtractor: out_diff = in_a - in_b - in_bin (mod 2^WIDTH).
// Stage 1 subtracts the low half, stage 2 the high half using the registered borrow.
// Valid/ready handshake on both sides with full backpressure support.
// Optional flags (out_zero/out_ovf/out_lt) are built only when SUB_PIPE_FLAGS_EN is defined;
// otherwise they read 0.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake
//   in_a, in_b, in_bin    minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake
//   out_diff, out_bout    difference and borrow-out
//   out_zero, out_ovf, out_lt  diff==0, signed overflow, signed less-than
module sub_pipe2
  import sub_pipe_defs::*;
#(
  parameter int unsigned WIDTH = DefaultWidth  // must be even
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_lt
);

  localparam int unsigned H = WIDTH / 2;

  logic         r_s1_valid;
  logic         r_s2_valid;
  logic [H-1:0] r_diff_lo;
  logic         r_borrow_lo;
  logic [H-1:0] r_a_hi;
  logic [H-1:0] r_b_hi;
  logic [WIDTH-1:0] r_diff;
  logic         r_bout;

  logic         w_s1_load;
  logic         w_s2_adv;
  logic         w_s1_valid_d;
  logic         w_s2_valid_d;
  logic [H-1:0] w_lo_diff;
  logic         w_lo_bout;
  logic [H-1:0] w_hi_diff;
  logic         w_hi_bout;

  // Handshake: stage 2 frees up when empty or when the consumer takes it this cycle.
  assign w_s2_adv  = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready  = ~r_s1_valid | w_s2_adv;
  assign w_s1_load = in_valid & in_ready;

  assign w_s1_valid_d = w_s1_load | (r_s1_valid & ~w_s2_adv);
  assign w_s2_valid_d = w_s2_adv | (r_s2_valid & ~out_ready);

  sub_half #(
    .H (H)
  ) u_sub_lo (
    .i_a    (in_a[H-1:0]),
    .i_b    (in_b[H-1:0]),
    .i_bin  (in_bin),
    .o_diff (w_lo_diff),
    .o_bout (w_lo_bout)
  );

  sub_half #(
    .H (H)
  ) u_sub_hi (
    .i_a    (r_a_hi),
    .i_b    (r_b_hi),
    .i_bin  (r_borrow_lo),
    .o_diff (w_hi_diff),
    .o_bout (w_hi_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= RstValid;
      r_s2_valid <= RstValid;
    end else begin
      r_s1_valid <= w_s1_valid_d;
      r_s2_valid <= w_s2_valid_d;
    end
  end

  // Stage 1 data: loads only on accept so held operands survive bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff_lo   <= '0;
      r_borrow_lo <= RstBorrow;
      r_a_hi      <= '0;
      r_b_hi      <= '0;
    end else if (w_s1_load) begin
      r_diff_lo   <= w_lo_diff;
      r_borrow_lo <= w_lo_bout;
      r_a_hi      <= in_a[WIDTH-1:H];
      r_b_hi      <= in_b[WIDTH-1:H];
    end
  end

  // Stage 2 data: loads only on stage advance, so a stalled result stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_bout <= RstBorrow;
    end else if (w_s2_adv) begin
      r_diff <= {w_hi_diff, r_diff_lo};
      r_bout <= w_hi_bout;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_diff  = r_diff;
  assign out_bout  = r_bout;

`ifdef SUB_PIPE_FLAGS_EN
  logic r_zero_lo;
  logic r_zero;
  logic r_ovf;
  logic r_lt;
  logic w_ovf;

  // Sign bits come from the registered upper operand halves.
  assign w_ovf = (r_a_hi[H-1] != r_b_hi[H-1]) & (w_hi_diff[H-1] != r_a_hi[H-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_lo <= RstFlag;
    end else if (w_s1_load) begin
      r_zero_lo <= (w_lo_diff == '0);
    end
  end

  // Zero is split across stages so no single stage does a full-width compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= RstFlag;
      r_ovf  <= RstFlag;
      r_lt   <= RstFlag;
    end else if (w_s2_adv) begin
      r_zero <= r_zero_lo & (w_hi_diff == '0);
      r_ovf  <= w_ovf;
      r_lt   <= w_hi_diff[H-1] ^ w_ovf;
    end
  end

  assign out_zero = r_zero;
  assign out_ovf  = r_ovf;
  assign out_lt   = r_lt;
`else
  assign out_zero = 1'b0;
  assign out_ovf  = 1'b0;
  assign out_lt   = 1'b0;
`endif

endmodule

// File: tb/tb_sub_pipe2.sv
module tb_sub_pipe2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_diff;
  logic        out_bout;
  logic        out_zero;
  logic        out_ovf;
  logic        out_lt;

  int tests;
  int fails;
  int deliv_cnt;

  logic [35:0] exp_q[$];
  logic [35:0] prev_obs;
  logic        prev_stall;

  sub_pipe2 #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_bout  (out_bout),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_lt    (out_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference: {lt, ovf, zero, bout, diff} from plain wide arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic bin);
    logic [32:0] u;
    longint      s;
    logic        zero;
    logic        ovf;
    logic        lt;
    u = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    s = longint'($signed(a)) - longint'($signed(b)) - longint'({63'd0, bin});
`ifdef SUB_PIPE_FLAGS_EN
    zero = (u[31:0] == 32'd0);
    ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    lt   = (s < 0);
`else
    zero = 1'b0;
    ovf  = 1'b0;
    lt   = 1'b0;
`endif
    return {lt, ovf, zero, u[32], u[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after inputs settle, score handshakes, advance to next negedge.
  task automatic step();
    logic [35:0] obs;
    #1;
    obs = {out_lt, out_ovf, out_zero, out_bout, out_diff};
    if (prev_stall) chk("hold", 64'({out_valid, obs}), 64'({1'b1, prev_obs}));
    if (out_valid && out_ready) begin
      deliv_cnt++;
      if (exp_q.size() == 0) chk("spurious", 64'(out_valid), 64'd0);
      else chk("result", 64'(obs), 64'(exp_q.pop_front()));
    end
    prev_stall = out_valid && !out_ready;
    prev_obs   = obs;
    if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_bin));
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic bin);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_bin   = bin;
  endtask

  task automatic idle_steps(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [31:0] dir_a[6];
  logic [31:0] dir_b[6];
  logic        dir_bin[6];
  int          cnt0;

  initial begin
    tests      = 0;
    fails      = 0;
    deliv_cnt  = 0;
    prev_stall = 1'b0;
    prev_obs   = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_bin     = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", 64'(out_diff), 64'd0);
    chk("rst_flags", 64'({out_bout, out_zero, out_ovf, out_lt}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Basic: borrow across the half boundary, with latency check
    out_ready = 1'b1;
    drive(32'h0001_0000, 32'h0000_0001, 1'b0);
    step();
    in_valid = 1'b0;
    chk("lat1_valid", 64'(out_valid), 64'd0);
    step();
    chk("lat2_valid", 64'(out_valid), 64'd1);
    chk("basic_diff", 64'({out_bout, out_diff}), 64'({1'b0, 32'h0000_FFFF}));
    step();

    // Wrap: 0 - 1
    drive(32'd0, 32'd1, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    chk("wrap_diff", 64'({out_bout, out_diff}), 64'({1'b1, 32'hFFFF_FFFF}));
    step();

    // Directed corner vectors, streamed
    dir_a[0] = 32'h8000_0000; dir_b[0] = 32'h0000_0001; dir_bin[0] = 1'b0;
    dir_a[1] = 32'h1234_5678; dir_b[1] = 32'h1234_5678; dir_bin[1] = 1'b0;
    dir_a[2] = 32'hFFFF_FFFF; dir_b[2] = 32'hFFFF_FFFF; dir_bin[2] = 1'b1;
    dir_a[3] = 32'h7FFF_FFFF; dir_b[3] = 32'hFFFF_FFFF; dir_bin[3] = 1'b0;
    dir_a[4] = 32'h0000_0000; dir_b[4] = 32'h8000_0000; dir_bin[4] = 1'b1;
    dir_a[5] = 32'h0000_0000; dir_b[5] = 32'h0000_FFFF; dir_bin[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(dir_a[i], dir_b[i], dir_bin[i]);
      #1;
      chk("dir_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    idle_steps(3);

    // Streaming: 8 back-to-back pairs with out_ready held high
    cnt0 = deliv_cnt;
    for (int i = 0; i < 8; i++) begin
      drive($urandom, $urandom, 1'($urandom));
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    idle_steps(2);
    chk("stream_count", 64'(deliv_cnt - cnt0), 64'd8);
    idle_steps(2);

    // Backpressure: two accepts then stall
    out_ready = 1'b0;
    drive($urandom, $urandom, 1'($urandom));
    step();
    drive($urandom, $urandom, 1'($urandom));
    step();
    drive($urandom, $urandom, 1'($urandom));
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt0 = deliv_cnt;
    step();
    step();
    chk("bp_release_count", 64'(deliv_cnt - cnt0), 64'd2);
    idle_steps(2);

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       drive(32'd0, $urandom, 1'($urandom));
        1:       begin in_a = $urandom; drive(in_a, in_a, 1'b0); end
        2:       drive(32'h8000_0000, $urandom, 1'($urandom));
        default: drive($urandom, $urandom, 1'($urandom));
      endcase
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-flight with both stages full
    out_ready = 1'b0;
    drive($urandom, $urandom, 1'($urandom));
    step();
    drive($urandom, $urandom, 1'($urandom));
    step();
    in_valid = 1'b0;
    #1;
    chk("mid_full_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_diff", 64'(out_diff), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    end

    // Pipe still works after reset
    drive(32'h0000_0005, 32'h0000_0003, 1'b1);
    step();
    idle_steps(3);
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
